// File: rtl/cci_mpf_shim_vtp_pt_fim_server_pkg.sv
// Shared VTP page-table FIM service types: line address/data widths, walker write payload, channel FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cci_mpf_shim_vtp_pt_fim_server_pkg;

    localparam int CCI_CLADDR_WIDTH   = 42;
    localparam int CCI_CLDATA_WIDTH   = 512;
    localparam int PT_FIM_WDATA_WIDTH = 64;

    typedef logic [CCI_CLADDR_WIDTH-1:0]   t_cci_clAddr;
    typedef logic [CCI_CLDATA_WIDTH-1:0]   t_cci_clData;
    typedef logic [PT_FIM_WDATA_WIDTH-1:0] t_pt_fim_wdata;

    // A walker write carries address and data together through the generic channel
    typedef struct packed {
        t_cci_clAddr   addr;
        t_pt_fim_wdata data;
    } t_pt_fim_wr_req;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } t_cci_mpf_shim_vtp_pt_fim_state;

endpackage

// File: rtl/cci_mpf_shim_vtp_pt_fim_server_if.sv
// Walker <-> FIM read/write service bundle.
// Latency: n/a (wires only).
// Backpressure: walker may present readEn/writeEn only while readRdy/writeRdy are high.
// Ports (to_fim view): in readEn/readAddr, writeEn/writeAddr/writeData;
//                      out readRdy/readData/readDataEn, writeRdy/writeAckEn (write completion pulse).
interface cci_mpf_shim_vtp_pt_fim_if
    import cci_mpf_shim_vtp_pt_fim_server_pkg::*;
    ;

    logic          readEn;
    t_cci_clAddr   readAddr;
    logic          readRdy;
    t_cci_clData   readData;
    logic          readDataEn;

    logic          writeEn;
    t_cci_clAddr   writeAddr;
    t_pt_fim_wdata writeData;
    logic          writeRdy;
    logic          writeAckEn;

    modport to_fim (
        input  readEn, readAddr, writeEn, writeAddr, writeData,
        output readRdy, readData, readDataEn, writeRdy, writeAckEn
    );

    modport to_walker (
        output readEn, readAddr, writeEn, writeAddr, writeData,
        input  readRdy, readData, readDataEn, writeRdy, writeAckEn
    );

endinterface

// File: rtl/cci_mpf_shim_vtp_pt_fim_server_chan.sv
// One request/response channel: capture a request in IDLE, present it to the host in ISSUE, wait for a tagged reply.
// Latency: request visible to host 1 cycle after reqEn; rspDone is combinational in the cycle of the matching reply.
// Backpressure: holds memReqEn with a stable payload until memReqRdy; reqRdy only in IDLE; WAIT may be bounded.
// Ports: reqEn/reqPayload/reqRdy (client), memReq*/memRsp* (host), rspDone (+ timeoutHit with VTP_PT_FIM_TIMEOUT_EN).
module cci_mpf_shim_vtp_pt_fim_chan
    import cci_mpf_shim_vtp_pt_fim_server_pkg::*;
#(
    parameter int         PW  = 1,
    parameter logic [7:0] TAG = 8'h00
`ifdef VTP_PT_FIM_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 4096
`endif
)(
    input  logic          clk,
    input  logic          reset_n,

    input  logic          reqEn,
    input  logic [PW-1:0] reqPayload,
    output logic          reqRdy,

    output logic          memReqEn,
    output logic [PW-1:0] memReqPayload,
    output logic [7:0]    memReqTag,
    input  logic          memReqRdy,

    input  logic          memRspEn,
    input  logic [7:0]    memRspTag,
    output logic          rspDone
`ifdef VTP_PT_FIM_TIMEOUT_EN
    ,
    output logic          timeoutHit
`endif
);

    t_cci_mpf_shim_vtp_pt_fim_state state, nextState;
    logic [PW-1:0] payloadQ;
    logic          rspMatch;

    assign rspMatch      = memRspEn && (memRspTag == TAG);
    assign memReqPayload = payloadQ;
    assign memReqTag     = TAG;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            payloadQ <= '0;
        end else if (reqRdy && reqEn) begin
            payloadQ <= reqPayload;
        end
    end

`ifdef VTP_PT_FIM_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] waitCnt;
    logic             cntExpired;

    // Held at zero outside WAIT, so it is clear on every entry; the TIMEOUT_CYCLES-th WAIT cycle expires
    always_ff @(posedge clk) begin
        if (!reset_n || (state != WAIT)) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= waitCnt + CNT_W'(1);
        end
    end

    assign cntExpired = (state == WAIT) && (waitCnt == CNT_LAST);
`endif

    always_comb begin
        nextState = state;
        reqRdy    = 1'b0;
        memReqEn  = 1'b0;
        rspDone   = 1'b0;
`ifdef VTP_PT_FIM_TIMEOUT_EN
        timeoutHit = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Gated so the client sees not-ready while reset is held
                reqRdy = reset_n;
                if (reqEn) nextState = ISSUE;
            end
            ISSUE: begin
                memReqEn = reset_n;
                if (memReqRdy) nextState = WAIT;
            end
            WAIT: begin
                // A reply arriving on the expiry cycle still wins over the timeout
                if (rspMatch) begin
                    rspDone   = 1'b1;
                    nextState = IDLE;
                end
`ifdef VTP_PT_FIM_TIMEOUT_EN
                else if (cntExpired) begin
                    rspDone    = 1'b1;
                    timeoutHit = 1'b1;
                    nextState  = IDLE;
                end
`endif
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: rtl/cci_mpf_shim_vtp_pt_fim_server.sv
// VTP page-table FIM server: turns walker reads/writes into tagged host line requests on two independent channels.
// Latency: readEn -> memRdReqEn next cycle; readDataEn one cycle after the matching response (same for write ack).
// Backpressure: memRd/WrReqEn held until the host is ready; readRdy/writeRdy low while a channel is busy.
// Ports: clk, reset_n (sync, active-low), pt_fim (to_fim), memRdReq*/memRdRsp*, memWrReq*/memWrAck*, timeoutErr.
// Build option: define VTP_PT_FIM_TIMEOUT_EN to bound each WAIT by TIMEOUT_CYCLES (sticky timeoutErr, read
// completes with all-ones data); without it timeoutErr is 0 and WAIT is unbounded.
module cci_mpf_shim_vtp_pt_fim_server
    import cci_mpf_shim_vtp_pt_fim_server_pkg::*;
#(
    parameter logic [7:0] RD_TAG         = 8'h5A,
    parameter logic [7:0] WR_TAG         = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 4096
)(
    input  logic        clk,
    input  logic        reset_n,

    cci_mpf_shim_vtp_pt_fim_if.to_fim pt_fim,

    output logic        memRdReqEn,
    output t_cci_clAddr memRdReqAddr,
    output logic [7:0]  memRdReqTag,
    input  logic        memRdReqRdy,

    input  logic        memRdRspEn,
    input  logic [7:0]  memRdRspTag,
    input  t_cci_clData memRdRspData,

    output logic        memWrReqEn,
    output t_cci_clAddr memWrReqAddr,
    output logic [7:0]  memWrReqTag,
    output t_cci_clData memWrReqData,
    input  logic        memWrReqRdy,

    input  logic        memWrAckEn,
    input  logic [7:0]  memWrAckTag,

    output logic        timeoutErr
);

    logic           rdDone, wrDone, rdTimeout;
    t_pt_fim_wr_req wrReqIn, wrReqOut;
    t_cci_clData    readDataQ;
    logic           readDataEnQ, writeAckEnQ;

    cci_mpf_shim_vtp_pt_fim_chan #(
        .PW  (CCI_CLADDR_WIDTH),
        .TAG (RD_TAG)
`ifdef VTP_PT_FIM_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) rdChan (
        .clk           (clk),
        .reset_n       (reset_n),
        .reqEn         (pt_fim.readEn),
        .reqPayload    (pt_fim.readAddr),
        .reqRdy        (pt_fim.readRdy),
        .memReqEn      (memRdReqEn),
        .memReqPayload (memRdReqAddr),
        .memReqTag     (memRdReqTag),
        .memReqRdy     (memRdReqRdy),
        .memRspEn      (memRdRspEn),
        .memRspTag     (memRdRspTag),
        .rspDone       (rdDone)
`ifdef VTP_PT_FIM_TIMEOUT_EN
        ,
        .timeoutHit    (rdTimeout)
`endif
    );

    assign wrReqIn = '{addr: pt_fim.writeAddr, data: pt_fim.writeData};

`ifdef VTP_PT_FIM_TIMEOUT_EN
    logic wrTimeout;
`endif

    cci_mpf_shim_vtp_pt_fim_chan #(
        .PW  ($bits(t_pt_fim_wr_req)),
        .TAG (WR_TAG)
`ifdef VTP_PT_FIM_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) wrChan (
        .clk           (clk),
        .reset_n       (reset_n),
        .reqEn         (pt_fim.writeEn),
        .reqPayload    (wrReqIn),
        .reqRdy        (pt_fim.writeRdy),
        .memReqEn      (memWrReqEn),
        .memReqPayload (wrReqOut),
        .memReqTag     (memWrReqTag),
        .memReqRdy     (memWrReqRdy),
        .memRspEn      (memWrAckEn),
        .memRspTag     (memWrAckTag),
        .rspDone       (wrDone)
`ifdef VTP_PT_FIM_TIMEOUT_EN
        ,
        .timeoutHit    (wrTimeout)
`endif
    );

    assign memWrReqAddr = wrReqOut.addr;
    assign memWrReqData = {{(CCI_CLDATA_WIDTH-PT_FIM_WDATA_WIDTH){1'b0}}, wrReqOut.data};

`ifndef VTP_PT_FIM_TIMEOUT_EN
    assign rdTimeout = 1'b0;
`endif

    // readData keeps its last value between completions; a timed-out read completes with all-ones
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readDataQ   <= '0;
            readDataEnQ <= 1'b0;
            writeAckEnQ <= 1'b0;
        end else begin
            readDataEnQ <= rdDone;
            writeAckEnQ <= wrDone;
            if (rdDone) readDataQ <= rdTimeout ? '1 : memRdRspData;
        end
    end

    assign pt_fim.readData   = readDataQ;
    assign pt_fim.readDataEn = readDataEnQ;
    assign pt_fim.writeAckEn = writeAckEnQ;

`ifdef VTP_PT_FIM_TIMEOUT_EN
    logic timeoutErrQ;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timeoutErrQ <= 1'b0;
        end else if (rdTimeout || wrTimeout) begin
            timeoutErrQ <= 1'b1;
        end
    end

    assign timeoutErr = timeoutErrQ;
`else
    assign timeoutErr = 1'b0;
`endif

endmodule
